dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the 16-bit data memory. It shares the single memory port between the CPU load/store unit (port 0) and a DMA/debug requester (port 1). Arbitration is round-robin. Each access is held for a fixed number of wait states, and completion is signalled with a one-cycle acknowledge. It sits between the execute/memory stage and the data memory, and drives the memory's address, write-data and read/write strobes.

## Interface
- WAIT_CYCLES, default 1: extra cycles the strobes are held beyond the first; range 0..15.
- clk  in  1  rising-edge clock
- rst  in  1  reset rst, synchronous, active-high
- p0_req / p1_req  in  1  access request; level, held until the matching ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high
- p0_addr / p1_addr  in  16  word address; stable while req is high
- p0_wdata / p1_wdata  in  16  write data; stable while req is high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  16  read data; valid from the ack cycle, held until the next read completes on that port
- mem_addr  out  16  memory word address
- mem_wdata  out  16  memory write data
- mem_rd / mem_wr  out  1  memory read/write strobes; never both high
- mem_rdata  in  16  memory read data; combinational from mem_addr while mem_rd is high
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Requests are sampled only in IDLE.
  - If any req is high, latch the winner's port, we, addr and wdata into internal registers, load the wait counter with WAIT_CYCLES, and go to ACCESS.
- **Arbitration**
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins.
  - A last-grant register is updated on every grant. Its reset value is 1, so port 0 wins the first tie.
- **ACCESS**
  - mem_addr and mem_wdata come from the latched registers.
  - mem_rd = !we_latched and mem_wr = we_latched, both registered.
  - The counter decrements each cycle.
  - On the cycle the counter is 0:
    - for a read, capture mem_rdata into the winner's rdata register;
    - go to DONE.
- **DONE**
  - Strobes are low.
  - The winner's ack is high for exactly this cycle; the other ack stays 0.
  - Go to IDLE.
- **Requester rule:** deassert req in the cycle after ack unless issuing a new access. A req still high in IDLE is treated as a new access.
- **Dropped request:** a req deasserted before its ack does not abort the access. The access completes and the ack is still pulsed.
- Writes leave p*_rdata unchanged.
- mem_addr and mem_wdata hold their last values in IDLE and DONE; only the strobes qualify them.

## Timing
- **Reset values:** state IDLE, mem_rd = mem_wr = 0, mem_addr = mem_wdata = 0, p0_ack = p1_ack = 0, p0_rdata = p1_rdata = 0, busy = 0, last-grant = 1.
- **Reset in ACCESS or DONE:** strobes and acks are 0 from the next cycle. No ack is issued for the aborted access, and no rdata is captured.
- **Latency:**
  - req sampled at edge E: strobes are high in cycles E+1 .. E+1+WAIT_CYCLES.
  - ack is high in cycle E+2+WAIT_CYCLES.
  - Total: WAIT_CYCLES+3 cycles between accepted requests (ACCESS WAIT_CYCLES+1, DONE 1, IDLE 1).
  - With WAIT_CYCLES=1, a req present at edge 0 gives strobes in cycles 1–2 and ack in cycle 3.
- **Simultaneous events:**
  - A new request arriving during ACCESS/DONE waits until IDLE.
  - Both ports requesting continuously alternate 0,1,0,1…
  - Neither port waits more than one other access.
- **Width rules:** WAIT_CYCLES=0 gives a single ACCESS cycle. The counter is 4 bits and does not wrap, because it reloads only in IDLE.

## Test plan
- **Single read:** WAIT_CYCLES=1, memory word 0x0010 = 0xBEEF; p0 read of addr 0x0010 at edge 0 → mem_rd high in cycles 1–2 with mem_addr = 0x0010; p0_ack in cycle 3; p0_rdata = 0xBEEF; p1_ack stays 0.
- **Write then read-back:** p1 writes 0x1234 to 0x0100 → mem_wr high for 2 cycles, mem_rd 0, then p1_ack. A following p1 read of 0x0100 → p1_rdata = 0x1234. p0_rdata is unchanged.
- **Tie and fairness:** p0 and p1 both hold req for 6 back-to-back accesses after reset → grant order 0,1,0,1,0,1; one ack every 4 cycles; each ack goes only to its port.
- **Streaming DMA:** p1 requests continuously and p0 asserts one read mid-stream → p0 is granted at the first IDLE after the current p1 access and acks within 8 cycles.
- **Reset mid-access:** rst asserted in the second ACCESS cycle of a p0 read → strobes 0 the next cycle, no p0_ack, p0_rdata = 0, busy = 0, and a p0/p1 tie afterwards grants p0.
- **WAIT_CYCLES=0:** p0 read → exactly one mem_rd cycle; ack 2 cycles after the sampling edge; back-to-back accesses every 3 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer sharing the single
// data-memory port between the CPU load/store unit (port 0) and a DMA/debug
// requester (port 1). Each access holds the strobes for WAIT_CYCLES+1 cycles
// and finishes with a one-cycle acknowledge to the port that was granted.
module dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1  // extra strobe cycles, 0..15
) (
  input  logic        clk,
  input  logic        rst,
  // port 0: CPU load/store unit
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [15:0] p0_addr_i,
  input  logic [15:0] p0_wdata_i,
  output logic        p0_ack_o,
  output logic [15:0] p0_rdata_o,
  // port 1: DMA/debug requester
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [15:0] p1_addr_i,
  input  logic [15:0] p1_wdata_i,
  output logic        p1_ack_o,
  output logic [15:0] p1_rdata_o,
  // data memory port
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic [15:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // remaining extra strobe cycles
  logic        port_q, port_d;      // port owning the current access
  logic        last_q, last_d;      // port granted most recently
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;      // drives mem_addr_o directly
  logic [15:0] wdata_q, wdata_d;    // drives mem_wdata_o directly
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        grant;

  // State register and all registered outputs; rst clears everything and
  // leaves last-grant at 1 so port 0 wins the first tie.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state, arbitration and next-output logic.
  // NOTE: every variable gets a default before the case statement; a path
  // that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    grant    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A lone requester wins; on a tie the port not granted last wins.
        grant = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;
        if (p0_req_i || p1_req_i) begin
          port_d  = grant;
          last_d  = grant;
          we_d    = grant ? p1_we_i    : p0_we_i;
          addr_d  = grant ? p1_addr_i  : p0_addr_i;
          wdata_d = grant ? p1_wdata_i : p0_wdata_i;
          cnt_d   = WAIT_INIT;
          rd_d    = ~we_d;
          wr_d    = we_d;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: mem_rdata_i is valid now, capture it.
          if (!we_q) begin
            if (port_q) rdata1_d = mem_rdata_i;
            else        rdata0_d = mem_rdata_i;
          end
          ack0_d  = ~port_q;
          ack1_d  = port_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = ~we_q;
          wr_d  = we_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_rd_o    = rd_q;
  assign mem_wr_o    = wr_q;
  assign p0_ack_o    = ack0_q;
  assign p1_ack_o    = ack1_q;
  assign p0_rdata_o  = rdata0_q;
  assign p1_rdata_o  = rdata1_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: two instances (WAIT_CYCLES=1 as index 0,
// WAIT_CYCLES=0 as index 1), each with its own small memory. A timeline model
// (cycles elapsed since the grant) predicts every output on every cycle;
// directed tests add hand-computed literal expectations.
module tb_dmem_arbiter;

  localparam int W_A = 1;
  localparam int W_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        preload;
  logic        p0_req [2];
  logic        p1_req [2];
  logic        p0_we [2];
  logic        p1_we [2];
  logic [15:0] p0_addr [2];
  logic [15:0] p1_addr [2];
  logic [15:0] p0_wdata [2];
  logic [15:0] p1_wdata [2];
  logic        p0_ack [2];
  logic        p1_ack [2];
  logic [15:0] p0_rdata [2];
  logic [15:0] p1_rdata [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        mem_rd [2];
  logic        mem_wr [2];
  logic        busy [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  dmem_arbiter #(.WAIT_CYCLES(W_A)) u_a (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req[0]), .p0_we_i(p0_we[0]), .p0_addr_i(p0_addr[0]),
    .p0_wdata_i(p0_wdata[0]), .p0_ack_o(p0_ack[0]), .p0_rdata_o(p0_rdata[0]),
    .p1_req_i(p1_req[0]), .p1_we_i(p1_we[0]), .p1_addr_i(p1_addr[0]),
    .p1_wdata_i(p1_wdata[0]), .p1_ack_o(p1_ack[0]), .p1_rdata_o(p1_rdata[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_rd_o(mem_rd[0]),
    .mem_wr_o(mem_wr[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  dmem_arbiter #(.WAIT_CYCLES(W_B)) u_b (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req[1]), .p0_we_i(p0_we[1]), .p0_addr_i(p0_addr[1]),
    .p0_wdata_i(p0_wdata[1]), .p0_ack_o(p0_ack[1]), .p0_rdata_o(p0_rdata[1]),
    .p1_req_i(p1_req[1]), .p1_we_i(p1_we[1]), .p1_addr_i(p1_addr[1]),
    .p1_wdata_i(p1_wdata[1]), .p1_ack_o(p1_ack[1]), .p1_rdata_o(p1_rdata[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_rd_o(mem_rd[1]),
    .mem_wr_o(mem_wr[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  // Memories: read data only while mem_rd is high, junk otherwise.
  logic [15:0] mem [2][4096];
  assign mem_rdata[0] = mem_rd[0] ? mem[0][mem_addr[0][11:0]] : 16'hDEAD;
  assign mem_rdata[1] = mem_rd[1] ? mem[1][mem_addr[1][11:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (preload) begin
      mem[0][12'h010] <= 16'hBEEF;
      mem[0][12'h020] <= 16'h1111;
      mem[0][12'h030] <= 16'h2222;
      mem[0][12'h100] <= 16'h0000;
      mem[1][12'h040] <= 16'hCAFE;
      mem[1][12'h050] <= 16'h5A5A;
    end else begin
      for (int k = 0; k < 2; k++)
        if (mem_wr[k]) mem[k][mem_addr[k][11:0]] <= mem_wdata[k];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: timeline since grant ----------------
  // t = -1 while idle; t = 1 on the first strobe cycle after the grant edge,
  // strobes while t <= W+1, ack at t == W+2, idle again after that.
  int          t [2];
  logic        m_last [2];
  logic        m_port [2];
  logic        m_we [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rd0 [2];
  logic [15:0] m_rd1 [2];
  logic        chk_en = 1'b0;

  function automatic int wc(input int k);
    return (k == 0) ? W_A : W_B;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        t[k] = -1;
        m_last[k] = 1'b1;
        m_port[k] = 1'b0;
        m_we[k] = 1'b0;
        m_addr[k] = 16'h0000;
        m_wdata[k] = 16'h0000;
        m_rd0[k] = 16'h0000;
        m_rd1[k] = 16'h0000;
      end else if (t[k] < 0) begin
        if (p0_req[k] || p1_req[k]) begin
          m_port[k] = (p0_req[k] && p1_req[k]) ? !m_last[k] : p1_req[k];
          m_last[k] = m_port[k];
          m_we[k] = m_port[k] ? p1_we[k] : p0_we[k];
          m_addr[k] = m_port[k] ? p1_addr[k] : p0_addr[k];
          m_wdata[k] = m_port[k] ? p1_wdata[k] : p0_wdata[k];
          t[k] = 1;
        end
      end else begin
        t[k] = t[k] + 1;
        if (t[k] == wc(k) + 2 && !m_we[k]) begin
          if (m_port[k]) m_rd1[k] = mem[k][m_addr[k][11:0]];
          else           m_rd0[k] = mem[k][m_addr[k][11:0]];
        end
        if (t[k] == wc(k) + 3) t[k] = -1;
      end
    end
    if (rst) chk_en = 1'b1;
  end

  // Compare process: every cycle, every output of both instances.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic strobe;
        logic ackc;
        strobe = (t[k] >= 1) && (t[k] <= wc(k) + 1);
        ackc   = (t[k] == wc(k) + 2);
        check($sformatf("u%0d mem_rd", k),    16'(mem_rd[k]),  16'(strobe && !m_we[k]));
        check($sformatf("u%0d mem_wr", k),    16'(mem_wr[k]),  16'(strobe && m_we[k]));
        check($sformatf("u%0d mem_addr", k),  mem_addr[k],     m_addr[k]);
        check($sformatf("u%0d mem_wdata", k), mem_wdata[k],    m_wdata[k]);
        check($sformatf("u%0d p0_ack", k),    16'(p0_ack[k]),  16'(ackc && !m_port[k]));
        check($sformatf("u%0d p1_ack", k),    16'(p1_ack[k]),  16'(ackc && m_port[k]));
        check($sformatf("u%0d p0_rdata", k),  p0_rdata[k],     m_rd0[k]);
        check($sformatf("u%0d p1_rdata", k),  p1_rdata[k],     m_rd1[k]);
        check($sformatf("u%0d busy", k),      16'(busy[k]),    16'(t[k] >= 1));
      end
    end
  end

  // Ack log per instance: granted port and cycle.
  int ack_port_a [$];
  int ack_cyc_a [$];
  int ack_port_b [$];
  int ack_cyc_b [$];
  always @(negedge clk) begin
    if (p0_ack[0] === 1'b1) begin ack_port_a.push_back(0); ack_cyc_a.push_back(cyc); end
    if (p1_ack[0] === 1'b1) begin ack_port_a.push_back(1); ack_cyc_a.push_back(cyc); end
    if (p0_ack[1] === 1'b1) begin ack_port_b.push_back(0); ack_cyc_b.push_back(cyc); end
    if (p1_ack[1] === 1'b1) begin ack_port_b.push_back(1); ack_cyc_b.push_back(cyc); end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input int port, input logic req,
                          input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    if (port == 0) begin
      p0_req[k] = req; p0_we[k] = we; p0_addr[k] = addr; p0_wdata[k] = wdata;
    end else begin
      p1_req[k] = req; p1_we[k] = we; p1_addr[k] = addr; p1_wdata[k] = wdata;
    end
  endtask

  // One complete access on one port; drops req in the cycle after ack.
  task automatic do_access(input int k, input int port, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata);
    logic got;
    got = 1'b0;
    set_port(k, port, 1'b1, we, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? p0_ack[k] : p1_ack[k];
    end
    check($sformatf("u%0d p%0d ack seen", k, port), 16'(got), 16'd1);
    tick();
    if (port == 0) p0_req[k] = 1'b0;
    else           p1_req[k] = 1'b0;
  endtask

  // Wait (bounded) for n acks on instance k, counted directly from the pins.
  task automatic wait_acks(input int k, input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 80 && seen < n; i++) begin
      @(negedge clk);
      if (p0_ack[k] === 1'b1 || p1_ack[k] === 1'b1) seen++;
    end
    check(name, 16'(seen), 16'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int base;
    int start_cyc;
    int p1_between;
    logic got;

    rst = 1'b1;
    preload = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_port(k, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_port(k, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    repeat (3) tick();
    preload = 1'b0;
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("reset busy", 16'(busy[0]), 16'd0);
    check("reset mem_addr", mem_addr[0], 16'h0000);
    check("reset p0_rdata", p0_rdata[0], 16'h0000);
    check("reset mem_rd", 16'(mem_rd[0]), 16'd0);

    // Single read, WAIT_CYCLES=1
    tick();
    set_port(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check("rd idle busy", 16'(busy[0]), 16'd0);
    @(negedge clk);
    check("rd strobe1", 16'(mem_rd[0]), 16'd1);
    check("rd addr", mem_addr[0], 16'h0010);
    @(negedge clk);
    check("rd strobe2", 16'(mem_rd[0]), 16'd1);
    @(negedge clk);
    check("rd strobe off", 16'(mem_rd[0]), 16'd0);
    check("rd p0_ack", 16'(p0_ack[0]), 16'd1);
    check("rd p1_ack", 16'(p1_ack[0]), 16'd0);
    check("rd p0_rdata", p0_rdata[0], 16'hBEEF);
    tick();
    p0_req[0] = 1'b0;
    @(negedge clk);
    check("rd ack one cycle", 16'(p0_ack[0]), 16'd0);

    // Write then read-back on port 1
    tick();
    set_port(0, 1, 1'b1, 1'b1, 16'h0100, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    check("wr strobe1", 16'(mem_wr[0]), 16'd1);
    check("wr no rd", 16'(mem_rd[0]), 16'd0);
    check("wr wdata", mem_wdata[0], 16'h1234);
    @(negedge clk);
    check("wr strobe2", 16'(mem_wr[0]), 16'd1);
    @(negedge clk);
    check("wr strobe off", 16'(mem_wr[0]), 16'd0);
    check("wr p1_ack", 16'(p1_ack[0]), 16'd1);
    tick();
    p1_req[0] = 1'b0;
    do_access(0, 1, 1'b0, 16'h0100, 16'h0000);
    check("readback p1_rdata", p1_rdata[0], 16'h1234);
    check("readback p0_rdata kept", p0_rdata[0], 16'hBEEF);

    // Tie and fairness: 6 back-to-back accesses
    tick();
    base = ack_port_a.size();
    set_port(0, 0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    set_port(0, 1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    wait_acks(0, 6, "tie ack count");
    tick();
    p0_req[0] = 1'b0;
    p1_req[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (base + i < ack_port_a.size())
        check($sformatf("tie order %0d", i), 16'(ack_port_a[base + i]), 16'(i % 2));
      if (i > 0 && base + i < ack_cyc_a.size())
        check($sformatf("tie spacing %0d", i),
              16'(ack_cyc_a[base + i] - ack_cyc_a[base + i - 1]), 16'd4);
    end
    check("tie p0_rdata", p0_rdata[0], 16'h1111);
    check("tie p1_rdata", p1_rdata[0], 16'h2222);

    // Streaming DMA with one p0 read mid-stream
    tick();
    set_port(0, 1, 1'b1, 1'b0, 16'h0100, 16'h0000);
    wait_acks(0, 1, "stream first ack");
    tick();
    tick();
    set_port(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    start_cyc = cyc;
    p1_between = 0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (p1_ack[0] === 1'b1) p1_between++;
      got = p0_ack[0];
    end
    check("stream p0 ack seen", 16'(got), 16'd1);
    check("stream p0 latency<=8", 16'((cyc - start_cyc) <= 8), 16'd1);
    check("stream p1 acks before p0", 16'(p1_between), 16'd1);
    tick();
    p0_req[0] = 1'b0;
    p1_req[0] = 1'b0;

    // Reset in the second ACCESS cycle of a p0 read
    tick();
    base = ack_port_a.size();
    set_port(0, 0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    tick();
    tick();
    rst = 1'b1;
    p0_req[0] = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst strobe", 16'(mem_rd[0]), 16'd0);
    check("rst busy", 16'(busy[0]), 16'd0);
    check("rst p0_ack", 16'(p0_ack[0]), 16'd0);
    check("rst p0_rdata", p0_rdata[0], 16'h0000);
    repeat (3) @(negedge clk);
    check("rst no ack logged", 16'(ack_port_a.size() - base), 16'd0);
    tick();
    set_port(0, 0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_port(0, 1, 1'b1, 1'b0, 16'h0030, 16'h0000);
    wait_acks(0, 1, "post-rst first ack");
    check("post-rst tie p0 wins", 16'(p0_ack[0]), 16'd1);
    check("post-rst tie p1 idle", 16'(p1_ack[0]), 16'd0);
    tick();
    p0_req[0] = 1'b0;
    p1_req[0] = 1'b0;
    repeat (4) tick();

    // WAIT_CYCLES=0 instance
    tick();
    set_port(1, 0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    @(negedge clk);
    check("w0 idle", 16'(mem_rd[1]), 16'd0);
    @(negedge clk);
    check("w0 strobe", 16'(mem_rd[1]), 16'd1);
    check("w0 addr", mem_addr[1], 16'h0040);
    @(negedge clk);
    check("w0 strobe off", 16'(mem_rd[1]), 16'd0);
    check("w0 ack", 16'(p0_ack[1]), 16'd1);
    check("w0 rdata", p0_rdata[1], 16'hCAFE);
    tick();
    p0_req[1] = 1'b0;
    tick();
    base = ack_port_b.size();
    set_port(1, 0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    set_port(1, 1, 1'b1, 1'b0, 16'h0050, 16'h0000);
    wait_acks(1, 4, "w0 tie ack count");
    tick();
    p0_req[1] = 1'b0;
    p1_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // last grant was port 0, so the tie starts with port 1
      if (base + i < ack_port_b.size())
        check($sformatf("w0 order %0d", i), 16'(ack_port_b[base + i]), 16'((i + 1) % 2));
      if (i > 0 && base + i < ack_cyc_b.size())
        check($sformatf("w0 spacing %0d", i),
              16'(ack_cyc_b[base + i] - ack_cyc_b[base + i - 1]), 16'd3);
    end
    check("w0 p1_rdata", p1_rdata[1], 16'h5A5A);

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
